// File: rtl/wb_dual_master_arb.sv
// wb_dual_master_arb
// Two Wishbone masters (m0 = CPU data port, m1 = instruction fetch) share one
// slave-side bus segment. The grant is decided in IDLE with round-robin
// priority, registered, and held for the whole bus cycle (cyc high).
// Optional stall timeout: define WB_ARB_TIMEOUT_EN to abort a transfer whose
// strobe sees no ack/err for TO_CYCLES consecutive cycles.
//
// Handshake: a transfer is offered while cyc and stb are both high; it
// completes in the cycle the slave raises ack (or err). The master keeps
// we/sel/adr/dat stable until it sees that termination. Read data is only
// valid in the ack cycle.
module wb_dual_master_arb #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int TO_W      = 8,
    parameter int TO_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    // data master
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    // fetch master
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    // shared slave-side port
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    // grant {m1,m0}, one-hot, 00 when nobody owns the bus
    output logic [1:0]      gnt_o,
    // current FSM state for observation
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        G0    = 2'd1,
        G1    = 2'd2,
        ABORT = 2'd3
    } state_t;

    state_t state;
    logic   last;       // master granted most recently; the other wins a tie

    logic            bus_on;
    logic            sel1;
    logic            mx_cyc;
    logic            mx_stb;
    logic            mx_we;
    logic [DW/8-1:0] mx_sel;
    logic [AW-1:0]   mx_adr;
    logic [DW-1:0]   mx_dat;
    logic            to_fire;

    // TO_CYCLES has to be representable in the counter
    if (TO_CYCLES >= (1 << TO_W)) begin : g_to_range
        $error("TO_CYCLES must be below 2**TO_W");
    end

    assign bus_on    = (state == G0) || (state == G1);
    assign sel1      = (state == G1);
    assign dbg_state = state;

    // select the request lines of the master that currently owns the bus
    always_comb begin
        mx_cyc = sel1 ? m1_cyc_i : m0_cyc_i;
        mx_stb = sel1 ? m1_stb_i : m0_stb_i;
        mx_we  = sel1 ? m1_we_i  : m0_we_i;
        mx_sel = sel1 ? m1_sel_i : m0_sel_i;
        mx_adr = sel1 ? m1_adr_i : m0_adr_i;
        mx_dat = sel1 ? m1_dat_i : m0_dat_i;
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
    logic            stalled;

    // a strobe is outstanding and the slave has not terminated it this cycle
    assign stalled = bus_on & mx_cyc & mx_stb & ~s_ack_i & ~s_err_i;
    // a real termination in the limit cycle wins over the forced abort
    assign to_fire = stalled & (to_cnt == TO_W'(TO_CYCLES));

    // count consecutive unterminated strobe cycles of the owning master
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (!stalled || to_fire) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end
`else
    assign to_fire = 1'b0;
`endif

    // route the owning master to the slave port; idle/abort drive zeros
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        if (bus_on) begin
            s_cyc_o = mx_cyc & ~to_fire;
            s_stb_o = mx_cyc & mx_stb & ~to_fire;
            s_we_o  = mx_we;
            s_sel_o = mx_sel;
            s_adr_o = mx_adr;
            s_dat_o = mx_dat;
        end
    end

    // terminations reach only the owning master; a late ack outside GX is dropped
    always_comb begin
        m0_ack_o = (state == G0) & s_ack_i;
        m0_err_o = (state == G0) & (s_err_i | to_fire);
        m1_ack_o = (state == G1) & s_ack_i;
        m1_err_o = (state == G1) & (s_err_i | to_fire);
    end

    // read data is broadcast; ack qualifies it
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    // grant FSM: arbitrate in IDLE, hold while cyc, release through IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            gnt_o <= 2'b00;
            last  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_cyc_i && (!m1_cyc_i || last)) begin
                        state <= G0;
                        gnt_o <= 2'b01;
                        last  <= 1'b0;
                    end else if (m1_cyc_i) begin
                        state <= G1;
                        gnt_o <= 2'b10;
                        last  <= 1'b1;
                    end
                end
                G0, G1: begin
                    if (!mx_cyc) begin
                        state <= IDLE;
                        gnt_o <= 2'b00;
                    end else if (to_fire) begin
                        state <= ABORT;
                        gnt_o <= 2'b00;
                    end
                end
                ABORT: begin
                    // the aborted master is the last one granted
                    if (!(last ? m1_cyc_i : m0_cyc_i)) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt_o <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_dual_master_arb.sv
// tb_wb_dual_master_arb
// Directed bench for wb_dual_master_arb. A reference model tracks bus
// ownership as "who owns the bus / who went last" and is compared against
// the DUT every cycle; directed tests add literal checks for the key cases.
// Build with WB_ARB_TIMEOUT_EN defined to include the timeout scenarios.
module tb_wb_dual_master_arb;

    localparam int TO_LIM = 8;
    localparam int BUDGET = 40;
`ifdef WB_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
    logic        m0_ack_o, m0_err_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
    logic        m1_ack_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic        s_ack_i, s_err_i;
    logic [1:0]  gnt_o;
    logic [1:0]  dbg_state;

    int n_vec;
    int n_err;
    int cyc_no;

    wb_dual_master_arb #(
        .AW(32), .DW(32), .TO_W(8), .TO_CYCLES(TO_LIM)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_sel_i(m0_sel_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_sel_i(m1_sel_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .gnt_o(gnt_o), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc_no <= cyc_no + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    // ---------------- comparison helper ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- slave responder ----------------
    // sl_lat: number of strobe cycles before termination (0 = never answer)
    int   sl_lat;
    bit   sl_err;
    int   sl_cnt;
    logic sl_hit;

    initial begin
        s_ack_i = 1'b0;
        s_err_i = 1'b0;
        s_dat_i = 32'h0;
        sl_cnt  = 0;
        forever begin
            @(negedge clk);
            sl_hit = s_cyc_o && s_stb_o && !s_ack_i && !s_err_i;
            @(posedge clk);
            #1;
            if (sl_hit) sl_cnt++;
            else sl_cnt = 0;
            s_ack_i = 1'b0;
            s_err_i = 1'b0;
            if (sl_hit && sl_lat != 0 && sl_cnt == sl_lat) begin
                if (sl_err) s_err_i = 1'b1;
                else s_ack_i = 1'b1;
                sl_cnt = 0;
            end
            s_dat_i = $urandom;
        end
    end

    // ---------------- reference model ----------------
    // own: 0 = nobody, 1 = m0, 2 = m1. last_m: index of most recent owner.
    int   own;
    int   last_m;
    bit   abort_f;
    int   stall;
    logic [1:0] cyc_v, stb_v;
    logic [1:0] exp_gnt, exp_ack, exp_err;
    logic       exp_s_cyc, exp_s_stb, exp_s_we, exp_tmo;
    logic [3:0] exp_s_sel;
    logic [31:0] exp_s_adr, exp_s_dat;

    assign cyc_v = {m1_cyc_i, m0_cyc_i};
    assign stb_v = {m1_stb_i, m0_stb_i};

    always_comb begin
        exp_gnt   = 2'b00;
        exp_ack   = 2'b00;
        exp_err   = 2'b00;
        exp_s_cyc = 1'b0;
        exp_s_stb = 1'b0;
        exp_s_we  = 1'b0;
        exp_s_sel = 4'h0;
        exp_s_adr = 32'h0;
        exp_s_dat = 32'h0;
        exp_tmo   = 1'b0;
        if (own == 1 || own == 2) begin
            exp_gnt   = (own == 1) ? 2'b01 : 2'b10;
            exp_tmo   = TO_EN && cyc_v[own-1] && stb_v[own-1] && !s_ack_i && !s_err_i
                        && (stall == TO_LIM);
            exp_s_cyc = cyc_v[own-1] && !exp_tmo;
            exp_s_stb = cyc_v[own-1] && stb_v[own-1] && !exp_tmo;
            exp_s_we  = (own == 1) ? m0_we_i  : m1_we_i;
            exp_s_sel = (own == 1) ? m0_sel_i : m1_sel_i;
            exp_s_adr = (own == 1) ? m0_adr_i : m1_adr_i;
            exp_s_dat = (own == 1) ? m0_dat_i : m1_dat_i;
            exp_ack[own-1] = s_ack_i;
            exp_err[own-1] = s_err_i || exp_tmo;
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            own     <= 0;
            last_m  <= 1;
            abort_f <= 1'b0;
            stall   <= 0;
        end else if (abort_f) begin
            stall <= 0;
            if (!cyc_v[last_m]) abort_f <= 1'b0;
        end else if (own == 0) begin
            stall <= 0;
            if (cyc_v == 2'b11) begin
                own    <= (1 - last_m) + 1;
                last_m <= 1 - last_m;
            end else if (cyc_v[0]) begin
                own    <= 1;
                last_m <= 0;
            end else if (cyc_v[1]) begin
                own    <= 2;
                last_m <= 1;
            end
        end else begin
            if (!cyc_v[own-1]) begin
                own <= 0;
            end else if (exp_tmo) begin
                own     <= 0;
                abort_f <= 1'b1;
            end
            if (s_ack_i || s_err_i || !(cyc_v[own-1] && stb_v[own-1]))
                stall <= 0;
            else
                stall <= stall + 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst) begin
            chk("gnt",    {62'b0, gnt_o},    {62'b0, exp_gnt});
            chk("s_cyc",  {63'b0, s_cyc_o},  {63'b0, exp_s_cyc});
            chk("s_stb",  {63'b0, s_stb_o},  {63'b0, exp_s_stb});
            chk("s_we",   {63'b0, s_we_o},   {63'b0, exp_s_we});
            chk("s_sel",  {60'b0, s_sel_o},  {60'b0, exp_s_sel});
            chk("s_adr",  {32'b0, s_adr_o},  {32'b0, exp_s_adr});
            chk("s_dat",  {32'b0, s_dat_o},  {32'b0, exp_s_dat});
            chk("acks",   {62'b0, m1_ack_o, m0_ack_o}, {62'b0, exp_ack});
            chk("errs",   {62'b0, m1_err_o, m0_err_o}, {62'b0, exp_err});
            chk("m0_dat", {32'b0, m0_dat_o}, {32'b0, s_dat_i});
            chk("m1_dat", {32'b0, m1_dat_o}, {32'b0, s_dat_i});
        end
    end

    // ---------------- grant history ----------------
    logic [1:0] prev_gnt;
    logic [1:0] gnt_seq[$];
    int         gnt_at0;
    int         drop_cyc[2];

    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            prev_gnt <= 2'b00;
        end else if (gnt_o !== prev_gnt) begin
            prev_gnt <= gnt_o;
            if (gnt_o != 2'b00) gnt_seq.push_back(gnt_o);
            if (gnt_o == 2'b01) gnt_at0 <= cyc_no;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_m(input int m, input logic cyc, input logic stb, input logic we,
                           input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
        if (m == 0) begin
            m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we;
            m0_adr_i = adr; m0_sel_i = sel; m0_dat_i = dat;
        end else begin
            m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we;
            m1_adr_i = adr; m1_sel_i = sel; m1_dat_i = dat;
        end
    endtask

    // wait (bounded) until master m sees ack or err; returns at the negedge of that cycle
    task automatic wait_term(input int m, input string nm);
        logic term;
        int   waited;
        term   = 1'b0;
        waited = 0;
        while (!term && waited < BUDGET) begin
            tick();
            @(negedge clk);
            term = (m == 0) ? (m0_ack_o | m0_err_o) : (m1_ack_o | m1_err_o);
            waited++;
        end
        chk(nm, {63'b0, term}, 64'd1);
    endtask

    // one bus cycle of n_acc back-to-back reads; cyc held low one cycle afterwards
    task automatic m_cycle(input int m, input int n_acc, input logic [31:0] adr);
        drive_m(m, 1'b1, 1'b1, 1'b0, adr, 4'hF, $urandom);
        for (int a = 0; a < n_acc; a++) begin
            wait_term(m, "m_term");
            tick();
            if (a < n_acc - 1)
                drive_m(m, 1'b1, 1'b1, 1'b0, adr + 32'(4 * (a + 1)), 4'hF, $urandom);
        end
        drive_m(m, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drop_cyc[m] = cyc_no;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
    endtask

    // ---------------- directed tests ----------------
    initial begin
        n_vec  = 0;
        n_err  = 0;
        cyc_no = 0;
        sl_lat = 1;
        sl_err = 1'b0;
        rst    = 1'b0;
        drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

        // reset state
        tick();
        chk("rst_gnt",  {62'b0, gnt_o}, 64'd0);
        chk("rst_scyc", {63'b0, s_cyc_o}, 64'd0);
        chk("rst_sadr", {32'b0, s_adr_o}, 64'd0);
        chk("rst_acks", {60'b0, m1_err_o, m1_ack_o, m0_err_o, m0_ack_o}, 64'd0);
        rst = 1'b1;
        tick();

        // single m0 read of 0x30000000, slave acks one cycle after stb
        drive_m(0, 1'b1, 1'b1, 1'b0, 32'h3000_0000, 4'hF, 32'h0);
        @(negedge clk);
        chk("t1_gnt_c0", {62'b0, gnt_o}, 64'h0);
        tick(); @(negedge clk);
        chk("t1_gnt_c1", {62'b0, gnt_o}, 64'h1);
        chk("t1_adr_c1", {32'b0, s_adr_o}, 64'h3000_0000);
        chk("t1_ack_c1", {63'b0, m0_ack_o}, 64'h0);
        tick(); @(negedge clk);
        chk("t1_ack_c2", {63'b0, m0_ack_o}, 64'h1);
        chk("t1_ack1_c2", {63'b0, m1_ack_o}, 64'h0);
        tick();
        drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("t1_scyc_c3", {63'b0, s_cyc_o}, 64'h0);
        tick(); @(negedge clk);
        chk("t1_gnt_c4", {62'b0, gnt_o}, 64'h0);
        tick();

        // simultaneous requests, four rounds: grants alternate starting with m0
        do_reset();
        gnt_seq.delete();
        for (int r = 0; r < 4; r++) begin
            fork
                m_cycle(0, 1, 32'h3000_1000 + 32'(r * 16));
                m_cycle(1, 1, 32'h0000_2000 + 32'(r * 16));
            join
        end
        chk("t2_len", 64'(gnt_seq.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            chk("t2_order", {62'b0, (i < gnt_seq.size()) ? gnt_seq[i] : 2'b00},
                (i % 2 == 0) ? 64'h1 : 64'h2);
        end

        // m1 burst of 3 while m0 waits: no switch until m1 drops cyc
        gnt_seq.delete();
        fork
            m_cycle(1, 3, 32'h0000_4000);
            begin
                tick();
                m_cycle(0, 1, 32'h3000_4000);
            end
        join
        chk("t3_len", 64'(gnt_seq.size()), 64'd2);
        chk("t3_first", {62'b0, (gnt_seq.size() > 0) ? gnt_seq[0] : 2'b00}, 64'h2);
        chk("t3_gap", 64'(gnt_at0 - drop_cyc[1]), 64'd2);

        // slave error on an m1 write
        sl_err = 1'b1;
        drive_m(1, 1'b1, 1'b1, 1'b1, 32'h3000_0100, 4'b0011, 32'h0000_BEEF);
        tick(); @(negedge clk);
        chk("t4_gnt", {62'b0, gnt_o}, 64'h2);
        chk("t4_sel", {60'b0, s_sel_o}, 64'h3);
        chk("t4_dat", {32'b0, s_dat_o}, 64'h0000_BEEF);
        chk("t4_we",  {63'b0, s_we_o}, 64'h1);
        tick(); @(negedge clk);
        chk("t4_m1err", {63'b0, m1_err_o}, 64'h1);
        chk("t4_m1ack", {63'b0, m1_ack_o}, 64'h0);
        chk("t4_m0",    {62'b0, m0_err_o, m0_ack_o}, 64'h0);
        tick();
        drive_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        sl_err = 1'b0;
        tick(); tick();

        // reset mid-cycle while m1 owns the bus, then a tie after release
        sl_lat = 0;
        drive_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_8000, 4'hF, 32'h0);
        tick(); @(negedge clk);
        chk("t5_gnt_pre", {62'b0, gnt_o}, 64'h2);
        #2;
        rst = 1'b0;
        #1;
        chk("t5_gnt_rst",  {62'b0, gnt_o}, 64'h0);
        chk("t5_cyc_rst",  {62'b0, s_cyc_o, s_stb_o}, 64'h0);
        chk("t5_adr_rst",  {32'b0, s_adr_o}, 64'h0);
        chk("t5_term_rst", {60'b0, m1_err_o, m1_ack_o, m0_err_o, m0_ack_o}, 64'h0);
        drive_m(0, 1'b1, 1'b1, 1'b0, 32'h3000_8000, 4'hF, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("t5_gnt_rel", {62'b0, gnt_o}, 64'h0);
        tick(); @(negedge clk);
        chk("t5_tie", {62'b0, gnt_o}, 64'h1);
        tick();
        drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick(); tick();
        sl_lat = 1;

`ifdef WB_ARB_TIMEOUT_EN
        // hung slave: err pulse in the 9th strobe cycle, then m1 takes over
        sl_lat = 0;
        drive_m(0, 1'b1, 1'b1, 1'b0, 32'h3000_0200, 4'hF, 32'h0);
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 1) drive_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_0300, 4'hF, 32'h0);
            @(negedge clk);
            chk("t6_err", {63'b0, m0_err_o}, (i == 9) ? 64'h1 : 64'h0);
            chk("t6_cyc", {63'b0, s_cyc_o}, (i == 9) ? 64'h0 : 64'h1);
        end
        tick();
        drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        sl_lat = 1;
        @(negedge clk);
        chk("t6_abort_cyc", {63'b0, s_cyc_o}, 64'h0);
        chk("t6_abort_gnt", {62'b0, gnt_o}, 64'h0);
        tick(); @(negedge clk);
        chk("t6_idle_gnt", {62'b0, gnt_o}, 64'h0);
        tick(); @(negedge clk);
        chk("t6_m1_gnt", {62'b0, gnt_o}, 64'h2);
        wait_term(1, "t6_m1_term");
        tick();
        drive_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick(); tick();

        // ack lands on the limit cycle: forwarded, no err
        sl_lat = TO_LIM;
        drive_m(0, 1'b1, 1'b1, 1'b0, 32'h3000_0400, 4'hF, 32'h0);
        for (int i = 1; i <= 9; i++) begin
            tick(); @(negedge clk);
            chk("t7_ack", {63'b0, m0_ack_o}, (i == 9) ? 64'h1 : 64'h0);
            chk("t7_err", {63'b0, m0_err_o}, 64'h0);
            chk("t7_cyc", {63'b0, s_cyc_o}, 64'h1);
        end
        tick();
        drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick(); tick();
        sl_lat = 1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_dual_master_arb.md
Name: wb_dual_master_arb

Overview:
- Two-master to one-slave Wishbone arbiter: CPU data port (m0, dwishbone) and instruction-fetch port (m1, iwishbone) share one upstream Wishbone master port (s_*).
- Used when a platform drops the full crossbar for a single shared bus segment feeding ROM, UART and GPIO.
- Round-robin grant, held for the whole cycle (cyc high), registered grant decision.

Parameters:
- AW, 32, address width.
- DW, 32, data width; sel width is DW/8.
- TO_W, 8, timeout counter width (used only with the optional feature).
- TO_CYCLES, 255, stb-without-ack cycles before a forced abort; must be < 2**TO_W.

Ports:
- clk  in  1  bus clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  data-master cycle, strobe and write enable.
- m0_sel_i  in  DW/8  byte selects.
- m0_adr_i  in  AW  address.
- m0_dat_i  in  DW  write data.
- m0_dat_o  out  DW  read data.
- m0_ack_o, m0_err_o  out  1 each  termination signals.
- m1_*  same set as m0_*, for the fetch master.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to the slave side.
- s_sel_o  out  DW/8.
- s_adr_o  out  AW.
- s_dat_o  out  DW.
- s_dat_i  in  DW.
- s_ack_i, s_err_i  in  1 each.
- gnt_o  out  2  one-hot current grant, {m1,m0}; 00 when idle.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state=IDLE, gnt_o=00, last=1 (m0 wins the first tie).
  - All s_* outputs 0; all m*_ack_o and m*_err_o 0.
- State machine: IDLE, G0, G1, ABORT.
- Request: mX_req = mX_cyc_i.
- IDLE:
  - Only m0_req -> G0. Only m1_req -> G1.
  - Both requesting -> the master not equal to last wins.
  - On entering GX, last <= X. No request -> stay in IDLE.
- Latency: a request in cycle N gives grant and slave visibility in cycle N+1. An isolated single access costs one arbitration cycle.
- GX (bus driven by master X):
  - s_cyc/stb/we/sel/adr/dat_o = master X inputs, combinational pass-through.
  - mX_ack_o = s_ack_i, mX_err_o = s_err_i.
  - The other master's ack and err are 0.
  - m0_dat_o = m1_dat_o = s_dat_i always; only ack qualifies the data.
- Grant held while mX_cyc_i=1, regardless of the other master. Back-to-back stb within one cyc (bursts, RMW) is never split.
- mX_cyc_i=0 in GX:
  - s_cyc_o/s_stb_o drop in the same cycle (combinational).
  - state -> IDLE next cycle.
  - Handover to the other master therefore takes one dead cycle.
- IDLE and ABORT drive all s_* outputs to 0; s_ack_i/s_err_i are ignored there.
- An ack arriving after the master dropped stb is not forwarded (the state is no longer GX).
- Simultaneous release by master X and a new request by X with the other master also requesting: the other master wins, because last=X.
- Reset asserted mid-transaction:
  - Outputs go to 0 immediately; no ack or err is generated.
  - The slave must tolerate cyc dropping.

Optional Feature:
- Macro WB_ARB_TIMEOUT_EN.
- Defined:
  - A TO_W-bit counter clears on entering GX, on s_ack_i or s_err_i, and whenever s_stb_o=0.
  - It increments each GX cycle with s_stb_o=1 and no termination.
  - When the count reaches TO_CYCLES: mX_err_o=1 for exactly that cycle, s_cyc_o/s_stb_o=0 that cycle, state -> ABORT.
  - ABORT holds the s_* outputs at 0 until mX_cyc_i=0, then goes to IDLE.
  - A real s_ack_i on the timeout cycle has priority: the ack is forwarded and no err is raised.
- Not defined: no counter, no ABORT state; a hung slave holds the grant indefinitely.

Test Plan:
- Reset, then m0 read of 0x30000000 with the slave acking one cycle after stb -> gnt_o=01 at cycle 1, s_adr_o=0x30000000, m0_ack_o one cycle, m1_ack_o=0; gnt_o=00 after m0 drops cyc.
- m0 and m1 raise cyc in the same cycle, 4 times in a row, each doing one access -> grants alternate m0, m1, m0, m1, with one idle cycle between grants.
- m1 holds cyc across 3 stb accesses while m0 requests throughout -> no switch until m1 cyc=0; m0 granted 2 cycles later.
- Slave returns s_err_i=1 for an m1 write (sel=4'b0011, dat=0x0000BEEF) -> m1_err_o=1, m1_ack_o=0, m0 outputs 0, s_sel_o=0011.
- Reset pulled low mid-cycle while gnt_o=10 -> all outputs 0 in the same cycle; after release, the first tie goes to m0.
- WB_ARB_TIMEOUT_EN, TO_CYCLES=8, slave never acks -> m0_err_o pulse in the 9th stb cycle, s_cyc_o=0 from then on; m1 granted after m0 drops cyc. Repeat with the ack arriving on that same cycle -> ack forwarded, no err.
